// File: rtl/multiword_add_sequencer.sv
// Wide two's-complement add/subtract built by stepping one WIDTH-bit ripple-carry
// adder over WORDS words, least-significant first, with the carry held in a register.

module rippleCarryAdder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    logic [WIDTH:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[WIDTH];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow = c[WIDTH] ^ c[WIDTH-1];
endmodule

module multiword_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [WORDS*WIDTH-1:0] a,
    input  logic [WORDS*WIDTH-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [WORDS*WIDTH-1:0] result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic                   zero
);
    localparam int K_W = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state, state_next;
    logic                         accept;
    logic [WORDS-1:0][WIDTH-1:0]  a_reg, b_reg, res_q, res_next;
    logic [K_W-1:0]               k;
    logic                         carry_reg, sub_reg;
    logic                         last;
    logic [WIDTH-1:0]             add_sum;
    logic                         add_cin, add_cout, add_ovf;

    assign last    = (k == K_LAST);
    assign add_cin = (k == '0) ? sub_reg : carry_reg;

    rippleCarryAdder #(.WIDTH(WIDTH)) u_adder (
        .a        (a_reg[k]),
        .b        (b_reg[k]),
        .cin      (add_cin),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    // Current result with word k replaced, so zero sees the word being written.
    always_comb begin
        res_next    = res_q;
        res_next[k] = add_sum;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                accept     = start;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand latches need no reset: they are only read after an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            res_q     <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            k       <= '0;
            sub_reg <= sub;
        end else if (state == RUN) begin
            res_q     <= res_next;
            carry_reg <= add_cout;
            if (last) begin
                carry_out <= add_cout;
                overflow  <= add_ovf;
                zero      <= (res_next == '0);
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = res_q;
endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Multi-precision signed adder/subtractor that computes a WORDS×WIDTH-bit result by sequencing one internal WIDTH-bit `rippleCarryAdder` over successive words, least-significant first, and chaining the carry through a register. It sits between a requesting datapath and the shared ripple-carry adder. It provides wide add/sub (default 128-bit) without a 128-bit combinational carry chain, and uses a start/busy/done handshake.

## Interface
- WIDTH, 32: bits per word; width of the internal `rippleCarryAdder`.
- WORDS, 4: number of words; minimum 2; operand width is WORDS*WIDTH.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when idle or in DONE.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WORDS*WIDTH  operand A, two's complement; sampled with start.
- b  input  WORDS*WIDTH  operand B, two's complement; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WORDS*WIDTH  sum or difference, registered.
- carry_out  output  1  cout of the top word; for sub, 1 = no borrow.
- overflow  output  1  signed overflow of the full-width operation, taken from the top-word adder.
- zero  output  1  result == 0; valid when done is high and held afterwards.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, word index k = 0..WORDS−1.
  - DONE: busy=0, done=1, lasts one cycle.
- Start acceptance:
  - IDLE or DONE, start=1: latch a into a_reg and (sub ? ~b : b) into b_reg; set k=0; go to RUN.
  - DONE, start=0: go to IDLE.
- Start rejection: start while in RUN is ignored. No latch, no error, and the current operation is unaffected.
- RUN, each cycle:
  - Adder inputs: a = a_reg word k, b = b_reg word k, cin = (k==0 ? sub_reg : carry_reg).
  - On the edge: result word k ← sum; carry_reg ← cout.
  - If k == WORDS−1: carry_out ← cout, overflow ← adder overflow, zero ← (all result words, including the one being written, == 0), go to DONE. Otherwise k ← k+1.
- Result words not yet processed keep their previous values during RUN. The full result is valid only from done onward.
- result, carry_out, overflow and zero hold their values after DONE until the next accepted start overwrites them.
- Arithmetic wraps modulo 2^(WORDS*WIDTH). Overflow follows the usual rule: operands of equal sign produce a result of the opposite sign, after b inversion for sub.

## Timing
- Reset, asynchronous:
  - Outputs: busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0.
  - Internal: state=IDLE, k=0, carry_reg=0.
  - Reset mid-RUN abandons the operation. No done pulse is produced.
- Latency: start accepted at edge E0; busy=1 after E0; words are written at edges E1..E_WORDS.
- Completion: after E_WORDS, done=1 and busy=0 for exactly one cycle. Latency is WORDS cycles from the accepting edge to done.
- Throughput: start held high during the DONE cycle is accepted at that edge. Back-to-back operations every WORDS+1 cycles; busy rises again the cycle after done.
- The done and busy outputs are never high in the same cycle.
- All outputs come from registers. The adder path (one WIDTH-bit ripple chain plus the cin mux) is the only combinational path per cycle.

## Test plan
All scenarios use WORDS=4, WIDTH=32.

1. Carry ripple across words: a=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, sub=0.
   - Required: result=0x0000_0001_0000_0000_0000_0000_0000_0000; carry_out=0, overflow=0, zero=0.
   - done exactly 4 cycles after the start edge; busy high for those 4 cycles.
2. Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1.
   - Required: result=0x8000_0000_0000_0000_0000_0000_0000_0000, overflow=1, carry_out=0.
   - Repeat with a=0x8000…0, b=−1: result=0x7FFF…F, overflow=1, carry_out=1.
3. Subtraction: a=100, b=150, sub=1.
   - Required: result=0xFFFF…FFCE (−50), carry_out=0, overflow=0, zero=0.
   - Then a=b=0x1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, sub=1: result=0, zero=1, carry_out=1.
4. Handshake:
   - Pulse start again 2 cycles into RUN with different operands: ignored, and the first result is unchanged.
   - Hold start high through the done cycle: the second operation is accepted, busy=1 the next cycle, and its done follows 4 cycles later.
5. Reset mid-run: assert rst asynchronously after 2 RUN cycles.
   - Required: all outputs 0 immediately, no done pulse.
   - A start after deassertion completes correctly, e.g. 200+150 gives 350.
